// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a RUN/HALTED fetch FSM.
// Branch redirects beat stalls, stalls beat jumps, and a fetched halt freezes the PC.
module if_stage #(
   parameter logic [15:0] NOP_INSTR = 16'h0000,
   parameter logic [3:0]  HLT_OP    = 4'b1111
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic        stall,
   input  logic        j_ctrl,
   input  logic [15:0] j_pc,
   input  logic        br_ctrl,
   input  logic [15:0] br_pc,
   output logic [15:0] instr,
   output logic [15:0] pc,
   output logic        halted
);

   typedef enum logic {RUN, HALTED} state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_reg_q, pc_reg_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] pc_q, pc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RUN;
         pc_reg_q <= 16'h0000;
         instr_q  <= NOP_INSTR;
         pc_q     <= 16'h0000;
      end else begin
         state_q  <= state_d;
         pc_reg_q <= pc_reg_d;
         instr_q  <= instr_d;
         pc_q     <= pc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_reg_d = pc_reg_q;
      instr_d  = instr_q;
      pc_d     = pc_q;
      if (br_ctrl) begin
         // A taken branch also cancels any wrong-path halt or jump.
         pc_reg_d = br_pc;
         instr_d  = NOP_INSTR;
         pc_d     = 16'h0000;
         state_d  = RUN;
      end else if (stall) begin
         state_d = state_q;
      end else if (j_ctrl) begin
         pc_reg_d = j_pc;
         instr_d  = NOP_INSTR;
         pc_d     = 16'h0000;
         state_d  = RUN;
      end else if (state_q == HALTED) begin
         instr_d = NOP_INSTR;
         pc_d    = 16'h0000;
      end else begin
         instr_d = imem_data;
         pc_d    = pc_reg_q;
         if (imem_data[15:12] == HLT_OP) begin
            state_d = HALTED;
         end else begin
            pc_reg_d = pc_reg_q + 16'h0001;
         end
      end
   end

   assign imem_addr = pc_reg_q;
   assign instr     = instr_q;
   assign pc        = pc_q;
   assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a behavioural fetch model queues expected IF/ID state per edge.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] imem_addr, imem_data, j_pc, br_pc, instr, pc;
   logic        stall, j_ctrl, br_ctrl, halted;
   logic [15:0] mem [0:65535];

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr];

   if_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .imem_addr (imem_addr),
      .imem_data (imem_data),
      .stall     (stall),
      .j_ctrl    (j_ctrl),
      .j_pc      (j_pc),
      .br_ctrl   (br_ctrl),
      .br_pc     (br_pc),
      .instr     (instr),
      .pc        (pc),
      .halted    (halted)
   );

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
      logic [15:0] addr;
      logic        halted;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [15:0] m_pc_reg, m_instr, m_pc;
   logic        m_halt;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc_reg = 16'h0000;
      m_instr  = 16'h0000;
      m_pc     = 16'h0000;
      m_halt   = 1'b0;
   endtask

   // One clock edge: drive controls, advance the model, push its prediction, then compare.
   task automatic step(input logic s, input logic j, input logic [15:0] jp,
                       input logic b, input logic [15:0] bp, input string tag);
      exp_t        e;
      logic [15:0] d;
      stall = s; j_ctrl = j; j_pc = jp; br_ctrl = b; br_pc = bp;
      if (b) begin
         m_pc_reg = bp; m_instr = 16'h0000; m_pc = 16'h0000; m_halt = 1'b0;
      end else if (s) begin
         m_halt = m_halt;
      end else if (j) begin
         m_pc_reg = jp; m_instr = 16'h0000; m_pc = 16'h0000; m_halt = 1'b0;
      end else if (m_halt) begin
         m_instr = 16'h0000; m_pc = 16'h0000;
      end else begin
         d = mem[m_pc_reg];
         m_instr = d;
         m_pc    = m_pc_reg;
         if (d[15:12] == 4'hF) m_halt = 1'b1;
         else m_pc_reg = m_pc_reg + 16'h0001;
      end
      e.instr = m_instr; e.pc = m_pc; e.addr = m_pc_reg; e.halted = m_halt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, "_instr"}, instr, e.instr);
      chk({tag, "_pc"}, pc, e.pc);
      chk({tag, "_addr"}, imem_addr, e.addr);
      chk({tag, "_halted"}, {15'b0, halted}, {15'b0, e.halted});
      stall = 1'b0; j_ctrl = 1'b0; br_ctrl = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      mem[0] = 16'h1123; mem[1] = 16'h2234; mem[2] = 16'h3345;
      mem[7] = 16'hF000; mem[16'hFFFF] = 16'h1234;
      mem[16'h0011] = 16'h4455;

      rst_n = 1'b0; stall = 1'b0; j_ctrl = 1'b0; br_ctrl = 1'b0;
      j_pc = 16'h0000; br_pc = 16'h0000;
      model_reset();
      #12;
      chk("rst_instr", instr, 16'h0000);
      chk("rst_pc", pc, 16'h0000);
      chk("rst_addr", imem_addr, 16'h0000);
      chk("rst_halted", {15'b0, halted}, 16'h0000);
      @(negedge clk) rst_n = 1'b1;

      // Sequential fetch
      step(0, 0, 0, 0, 0, "seq1");
      chk("seq1_k_instr", instr, 16'h1123); chk("seq1_k_pc", pc, 16'h0000);
      step(0, 0, 0, 0, 0, "seq2");
      chk("seq2_k_instr", instr, 16'h2234); chk("seq2_k_pc", pc, 16'h0001);
      step(0, 0, 0, 0, 0, "seq3");
      chk("seq3_k_instr", instr, 16'h3345); chk("seq3_k_pc", pc, 16'h0002);
      chk("seq3_k_addr", imem_addr, 16'h0003);
      step(0, 0, 0, 0, 0, "seq4");
      step(0, 0, 0, 0, 0, "seq5");
      chk("at5_addr", imem_addr, 16'h0005);

      // Jump
      step(0, 1, 16'h0040, 0, 0, "jmp");
      chk("jmp_k_instr", instr, 16'h0000); chk("jmp_k_addr", imem_addr, 16'h0040);
      step(0, 0, 0, 0, 0, "jmp_next");
      chk("jmp_k_pc", pc, 16'h0040);

      // Stall with jump held: jump waits until stall drops
      step(1, 1, 16'h0080, 0, 0, "stj1");
      chk("stj1_k_addr", imem_addr, 16'h0041); chk("stj1_k_pc", pc, 16'h0040);
      step(1, 1, 16'h0080, 0, 0, "stj2");
      chk("stj2_k_addr", imem_addr, 16'h0041); chk("stj2_k_pc", pc, 16'h0040);
      step(0, 1, 16'h0080, 0, 0, "stj3");
      chk("stj3_k_addr", imem_addr, 16'h0080);

      // Halt at address 7
      step(0, 1, 16'h0007, 0, 0, "to7");
      step(0, 0, 0, 0, 0, "hlt");
      chk("hlt_k_instr", instr, 16'hF000); chk("hlt_k_pc", pc, 16'h0007);
      chk("hlt_k_halted", {15'b0, halted}, 16'h0001);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 0, 0, "hold");
         chk("hold_k_instr", instr, 16'h0000);
         chk("hold_k_addr", imem_addr, 16'h0007);
         chk("hold_k_halted", {15'b0, halted}, 16'h0001);
      end

      // Branch out of HALTED, then branch beating jump and stall
      step(0, 0, 0, 1, 16'h0010, "brh");
      chk("brh_k_halted", {15'b0, halted}, 16'h0000);
      chk("brh_k_instr", instr, 16'h0000); chk("brh_k_addr", imem_addr, 16'h0010);
      step(0, 0, 0, 0, 0, "brh_next");
      step(0, 1, 16'h0099, 1, 16'h0020, "brj");
      chk("brj_k_addr", imem_addr, 16'h0020);
      step(1, 0, 0, 1, 16'h0030, "brs");
      chk("brs_k_addr", imem_addr, 16'h0030);

      // Wrap at the top of the address space
      step(0, 1, 16'hFFFF, 0, 0, "toFFFF");
      step(0, 0, 0, 0, 0, "wrap");
      chk("wrap_k_addr", imem_addr, 16'h0000);
      chk("wrap_k_instr", instr, 16'h1234); chk("wrap_k_pc", pc, 16'hFFFF);

      // Random control mix over a small address window
      for (int i = 0; i < 80; i++) begin
         step(($urandom % 5) == 0, ($urandom % 6) == 0, 16'($urandom_range(0, 15)),
              ($urandom % 8) == 0, 16'($urandom_range(0, 20)), "rnd");
      end

      // Asynchronous reset in the middle of a cycle
      step(0, 1, 16'h0033, 0, 0, "pre_rst");
      #3 rst_n = 1'b0;
      #1;
      chk("arst_instr", instr, 16'h0000);
      chk("arst_pc", pc, 16'h0000);
      chk("arst_addr", imem_addr, 16'h0000);
      chk("arst_halted", {15'b0, halted}, 16'h0000);
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      step(0, 0, 0, 0, 0, "post_rst");
      chk("post_rst_k_instr", instr, 16'h1123); chk("post_rst_k_pc", pc, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: NOP_INSTR, 16'h0000, bubble instruction (ADD R0,R0,R0) loaded into the IF/ID register on flush or halt.
REQ-002 Parameter: HLT_OP, 4'b1111, opcode field value instr[15:12] that identifies a halt.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: imem_addr  output  16  instruction memory word address, driven combinationally from the PC register.
REQ-006 Port: imem_data  input  16  instruction word at imem_addr, valid in the same cycle (combinational read).
REQ-007 Port: stall  input  1  hazard-unit hold request for PC and IF/ID.
REQ-008 Port: j_ctrl  input  1  decode-stage jump (JAL/JR) taken in this cycle.
REQ-009 Port: j_pc  input  16  jump target; valid when j_ctrl=1.
REQ-010 Port: br_ctrl  input  1  execute-stage branch taken; redirect and flush.
REQ-011 Port: br_pc  input  16  branch target; valid when br_ctrl=1.
REQ-012 Port: instr  output  16  IF/ID register: instruction presented to decode.
REQ-013 Port: pc  output  16  IF/ID register: word address of the instruction in instr.
REQ-014 Port: halted  output  1  fetch has passed a halt instruction and the PC is frozen.

Function
REQ-015 State: pc_reg (16), instr (16), pc (16), and a halt-pending flag that drives halted. Exactly two fetch states: RUN and HALTED.
REQ-016 imem_addr SHALL equal pc_reg at all times. Fetch-to-decode latency is 1 cycle.
REQ-017 Per-edge priority: br_ctrl > stall > j_ctrl > HALTED > sequential.
REQ-018 br_ctrl=1: pc_reg <= br_pc; instr <= NOP_INSTR; pc <= 16'h0000; state <= RUN. This applies even when stall=1 or state is HALTED, because the wrong-path halt is cancelled.
REQ-019 stall=1 and br_ctrl=0: pc_reg, instr, pc and state hold. j_ctrl is ignored that cycle; decode reasserts it after the stall.
REQ-020 j_ctrl=1, stall=0, br_ctrl=0: pc_reg <= j_pc; instr <= NOP_INSTR; pc <= 16'h0000; state <= RUN. The instruction fetched in that cycle is discarded.
REQ-021 Sequential, RUN, imem_data[15:12]!=HLT_OP: instr <= imem_data; pc <= pc_reg; pc_reg <= pc_reg+1.
REQ-022 Sequential, RUN, imem_data[15:12]==HLT_OP: instr <= imem_data; pc <= pc_reg; pc_reg holds; state <= HALTED.
REQ-023 HALTED with no branch/stall/jump: pc_reg holds; instr <= NOP_INSTR; pc <= 16'h0000.
REQ-024 halted SHALL be 1 exactly when state is HALTED.
REQ-025 PC arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 16'h0000 with no flag.
REQ-026 j_ctrl and br_ctrl together: br_ctrl wins, because the jump lies on the wrong path.

Reset
REQ-027 While rst_n=0, asynchronously: pc_reg=16'h0000, instr=NOP_INSTR, pc=16'h0000, state=RUN, halted=0. imem_addr therefore reads 16'h0000.
REQ-028 A reset asserted mid-stall, mid-jump or in HALTED SHALL override all other inputs. After release, the first fetch is from address 0.

Verification
REQ-029 Sequential run: imem[0..2]=16'h1123,16'h2234,16'h3345, no controls -> after edges 1,2,3: (instr,pc)=(1123,0),(2234,1),(3345,2); imem_addr=3.
REQ-030 Jump: at pc_reg=5, assert j_ctrl with j_pc=16'h0040 for one cycle -> next cycle instr=NOP_INSTR, imem_addr=16'h0040. The cycle after, pc=16'h0040.
REQ-031 Stall plus jump: stall=1 and j_ctrl=1 for 2 cycles, then stall=0 with j_ctrl=1 -> pc_reg, instr and pc unchanged for 2 cycles, then pc_reg=j_pc.
REQ-032 Halt: imem[7]=16'hF000 -> instr=F000 with pc=7, then halted=1, imem_addr stays 7, and instr=NOP_INSTR for 10 or more cycles.
REQ-033 Branch out of HALTED: while halted=1, br_ctrl=1 with br_pc=16'h0010 -> halted=0, instr=NOP_INSTR, imem_addr=16'h0010. Also check br_ctrl with j_ctrl together selects br_pc.
REQ-034 Wrap and reset: pc_reg=16'hFFFF -> next imem_addr=16'h0000. Pulse rst_n low asynchronously mid-cycle -> all outputs at reset values immediately.
